// File: rtl/prescaled_counter_pkg.sv
// Shared constants for the prescaled counter.
// Direction/mode encodings and the per-edge operation select.
package prescaled_counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DN    = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    typedef enum logic [1:0] {
        OP_CLR,
        OP_LOAD,
        OP_STEP,
        OP_HOLD
    } op_e;

endpackage

// File: rtl/prescaler_stage.sv
// Prescaler: counts enabled cycles and strobes o_term on the
// terminal cycle (pre >= pre_div), restarting from zero.
module prescaler_stage #(
    parameter int PRE_W = 2
) (
    input  logic             real_clk,
    input  logic             real_rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [PRE_W-1:0] pre_div,
    output logic             o_term
);

    logic [PRE_W-1:0] r_pre;

    // >= so a lowered pre_div terminates on the next enabled cycle
    assign o_term = en && !clr && !load && (r_pre >= pre_div);

    always_ff @(posedge real_clk or posedge real_rst) begin
        if (real_rst) begin
            r_pre <= '0;
        end else if (clr || load || o_term) begin
            r_pre <= '0;
        end else if (en) begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

endmodule

// File: rtl/prescaled_counter.sv
// Up/down counter stepped by a programmable prescaler, with
// wrap/saturate boundary handling and registered tick/wrap pulses.
module prescaled_counter
    import prescaled_counter_pkg::*;
#(
    parameter int               PRE_W = 2,
    parameter int               CNT_W = 3,
    parameter logic [CNT_W-1:0] INIT  = '0
) (
    input  logic             real_clk,
    input  logic             real_rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic [PRE_W-1:0] pre_div,
    input  logic             dir,
    input  logic             sat,
    output logic [CNT_W-1:0] count,
    output logic             tick,
    output logic             wrap,
    output logic             at_limit
);

    logic [CNT_W-1:0] r_count;
    logic             r_tick;
    logic             r_wrap;

    logic             w_term;
    logic             w_at_max;
    logic             w_at_min;
    op_e              w_op;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_tick_nxt;
    logic             w_wrap_nxt;

    prescaler_stage #(
        .PRE_W(PRE_W)
    ) u_pre (
        .real_clk(real_clk),
        .real_rst(real_rst),
        .en      (en),
        .clr     (clr),
        .load    (load),
        .pre_div (pre_div),
        .o_term  (w_term)
    );

    assign w_at_max = (r_count == '1);
    assign w_at_min = (r_count == '0);

    always_comb begin
        w_op = OP_HOLD;
        if (clr) begin
            w_op = OP_CLR;
        end else if (load) begin
            w_op = OP_LOAD;
        end else if (w_term) begin
            w_op = OP_STEP;
        end
    end

    always_comb begin
        w_cnt_nxt  = r_count;
        w_tick_nxt = 1'b0;
        w_wrap_nxt = 1'b0;
        unique case (w_op)
            OP_CLR:  w_cnt_nxt = '0;
            OP_LOAD: w_cnt_nxt = load_val;
            OP_STEP: begin
                w_tick_nxt = 1'b1;
                if (dir == DIR_UP) begin
                    if (!w_at_max) begin
                        w_cnt_nxt = r_count + CNT_W'(1);
                    end else if (sat == MODE_WRAP) begin
                        w_cnt_nxt  = '0;
                        w_wrap_nxt = 1'b1;
                    end
                end else begin
                    if (!w_at_min) begin
                        w_cnt_nxt = r_count - CNT_W'(1);
                    end else if (sat == MODE_WRAP) begin
                        w_cnt_nxt  = '1;
                        w_wrap_nxt = 1'b1;
                    end
                end
            end
            OP_HOLD: ;
        endcase
    end

    always_ff @(posedge real_clk or posedge real_rst) begin
        if (real_rst) begin
            r_count <= INIT;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_cnt_nxt;
            r_tick  <= w_tick_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    assign count    = r_count;
    assign tick     = r_tick;
    assign wrap     = r_wrap;
    assign at_limit = (dir == DIR_UP) ? w_at_max : w_at_min;

endmodule

// File: tb/tb_prescaled_counter.sv
// Bench for prescaled_counter: vector table, corner sequences and
// randomized traffic against an arithmetic reference model.
module tb_prescaled_counter;

    localparam int PRE_W = 2;
    localparam int CNT_W = 3;
    localparam int INIT  = 0;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             real_clk;
    logic             real_rst;
    logic             en;
    logic             clr;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic [PRE_W-1:0] pre_div;
    logic             dir;
    logic             sat;
    logic [CNT_W-1:0] count;
    logic             tick;
    logic             wrap;
    logic             at_limit;

    int nerr;
    int nchk;

    int m_pre;
    int m_cnt;
    int m_tick;
    int m_wrap;

    typedef struct {
        logic       e;
        logic       c;
        logic       l;
        logic [2:0] lv;
        logic [1:0] pd;
        logic       d;
        logic       s;
        int         ec;
        int         et;
        int         ew;
        int         el;
    } vec_t;

    vec_t vt[9];

    prescaled_counter #(
        .PRE_W(PRE_W),
        .CNT_W(CNT_W),
        .INIT (INIT[CNT_W-1:0])
    ) dut (
        .real_clk(real_clk),
        .real_rst(real_rst),
        .en      (en),
        .clr     (clr),
        .load    (load),
        .load_val(load_val),
        .pre_div (pre_div),
        .dir     (dir),
        .sat     (sat),
        .count   (count),
        .tick    (tick),
        .wrap    (wrap),
        .at_limit(at_limit)
    );

    initial real_clk = 1'b0;
    always #5 real_clk = ~real_clk;

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pre  = 0;
        m_cnt  = INIT;
        m_tick = 0;
        m_wrap = 0;
    endtask

    // Reference: plain arithmetic on integers following the step rules.
    task automatic model_edge();
        m_tick = 0;
        m_wrap = 0;
        if (clr) begin
            m_pre = 0;
            m_cnt = 0;
        end else if (load) begin
            m_pre = 0;
            m_cnt = int'(load_val);
        end else if (en) begin
            if (m_pre >= int'(pre_div)) begin
                m_pre  = 0;
                m_tick = 1;
                if (dir) begin
                    if (m_cnt == MAXC && sat) begin
                    end else begin
                        m_wrap = (m_cnt == MAXC) ? 1 : 0;
                        m_cnt  = (m_cnt + 1) % (MAXC + 1);
                    end
                end else begin
                    if (m_cnt == 0 && sat) begin
                    end else begin
                        m_wrap = (m_cnt == 0) ? 1 : 0;
                        m_cnt  = (m_cnt + MAXC) % (MAXC + 1);
                    end
                end
            end else begin
                m_pre = m_pre + 1;
            end
        end
    endtask

    task automatic cyc(input logic e, input logic c, input logic l,
                       input logic [2:0] lv, input logic [1:0] pd,
                       input logic d, input logic s);
        en       = e;
        clr      = c;
        load     = l;
        load_val = lv;
        pre_div  = pd;
        dir      = d;
        sat      = s;
        model_edge();
        @(posedge real_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        nerr = 0;
        nchk = 0;

        vt[0] = '{1'b0, 1'b0, 1'b1, 3'd2, 2'd0, 1'b0, 1'b1, 2, 0, 0, 0};
        vt[1] = '{1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 1, 1, 0, 0};
        vt[2] = '{1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 0, 1, 0, 1};
        vt[3] = '{1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 0, 1, 0, 1};
        vt[4] = '{1'b0, 1'b0, 1'b1, 3'd7, 2'd0, 1'b1, 1'b0, 7, 0, 0, 1};
        vt[5] = '{1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b1, 1'b0, 0, 1, 1, 0};
        vt[6] = '{1'b1, 1'b1, 1'b1, 3'd5, 2'd0, 1'b1, 1'b0, 0, 0, 0, 0};
        vt[7] = '{1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 0, 0, 0, 1};
        vt[8] = '{1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 7, 1, 1, 0};

        real_rst = 1'b1;
        en       = 1'b0;
        clr      = 1'b0;
        load     = 1'b0;
        load_val = '0;
        pre_div  = '0;
        dir      = 1'b1;
        sat      = 1'b0;
        model_reset();
        #12;
        chk("reset_count", int'(count), INIT);
        chk("reset_tick", int'(tick), 0);
        chk("reset_wrap", int'(wrap), 0);
        #1;
        real_rst = 1'b0;

        foreach (vt[i]) begin
            cyc(vt[i].e, vt[i].c, vt[i].l, vt[i].lv, vt[i].pd,
                vt[i].d, vt[i].s);
            chk($sformatf("vec%0d_count", i), int'(count), vt[i].ec);
            chk($sformatf("vec%0d_tick", i), int'(tick), vt[i].et);
            chk($sformatf("vec%0d_wrap", i), int'(wrap), vt[i].ew);
            chk($sformatf("vec%0d_lim", i), int'(at_limit), vt[i].el);
        end

        // Up count, period 4, one wrap at 7->0
        cyc(1'b0, 1'b1, 1'b0, 3'd0, 2'd3, 1'b1, 1'b0);
        for (int k = 1; k <= 32; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 3'd0, 2'd3, 1'b1, 1'b0);
            chk($sformatf("p4_count%0d", k), int'(count), (k / 4) % 8);
            chk($sformatf("p4_tick%0d", k), int'(tick),
                (k % 4 == 0) ? 1 : 0);
            chk($sformatf("p4_wrap%0d", k), int'(wrap),
                (k == 32) ? 1 : 0);
        end

        // Enable gaps hold the prescaler
        cyc(1'b0, 1'b1, 1'b0, 3'd0, 2'd1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 3'd0, 2'd1, 1'b1, 1'b0);
        chk("engap_t1", int'(tick), 0);
        cyc(1'b0, 1'b0, 1'b0, 3'd0, 2'd1, 1'b1, 1'b0);
        chk("engap_t2", int'(tick), 0);
        chk("engap_c2", int'(count), 0);
        cyc(1'b1, 1'b0, 1'b0, 3'd0, 2'd1, 1'b1, 1'b0);
        chk("engap_t3", int'(tick), 1);
        chk("engap_c3", int'(count), 1);
        cyc(1'b0, 1'b0, 1'b0, 3'd0, 2'd1, 1'b1, 1'b0);
        chk("engap_t4", int'(tick), 0);
        chk("engap_c4", int'(count), 1);

        // Lowering pre_div below pre gives an immediate terminal
        cyc(1'b0, 1'b1, 1'b0, 3'd0, 2'd3, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 3'd0, 2'd3, 1'b1, 1'b0);
            chk($sformatf("pdrop_pre%0d", k), int'(tick), 0);
        end
        cyc(1'b1, 1'b0, 1'b0, 3'd0, 2'd1, 1'b1, 1'b0);
        chk("pdrop_term", int'(tick), 1);
        chk("pdrop_cnt", int'(count), 1);
        cyc(1'b1, 1'b0, 1'b0, 3'd0, 2'd1, 1'b1, 1'b0);
        chk("pdrop_gap", int'(tick), 0);
        cyc(1'b1, 1'b0, 1'b0, 3'd0, 2'd1, 1'b1, 1'b0);
        chk("pdrop_next", int'(tick), 1);
        chk("pdrop_cnt2", int'(count), 2);

        // Async reset mid-prescale
        cyc(1'b0, 1'b0, 1'b1, 3'd5, 2'd3, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 3'd0, 2'd3, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 3'd0, 2'd3, 1'b1, 1'b0);
        chk("arst_pre_cnt", int'(count), 5);
        #2;
        real_rst = 1'b1;
        model_reset();
        #1;
        chk("arst_count", int'(count), INIT);
        chk("arst_tick", int'(tick), 0);
        #1;
        real_rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 3'd0, 2'd3, 1'b1, 1'b0);
            chk($sformatf("arst_tick%0d", k), int'(tick),
                (k == 4) ? 1 : 0);
        end
        chk("arst_cnt_end", int'(count), (INIT + 1) % (MAXC + 1));

        // Randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            logic       re;
            logic       rc;
            logic       rl;
            logic [2:0] rlv;
            logic [1:0] rpd;
            logic       rd;
            logic       rs;
            re  = ($urandom % 4) != 0;
            rc  = ($urandom % 25) == 0;
            rl  = ($urandom % 15) == 0;
            rlv = 3'($urandom);
            rpd = 2'($urandom);
            rd  = ($urandom % 8) != 0 ? dir : ~dir;
            rs  = 1'($urandom);
            cyc(re, rc, rl, rlv, rpd, rd, rs);
            chk($sformatf("rnd%0d_count", k), int'(count), m_cnt);
            chk($sformatf("rnd%0d_tick", k), int'(tick), m_tick);
            chk($sformatf("rnd%0d_wrap", k), int'(wrap), m_wrap);
            chk($sformatf("rnd%0d_lim", k), int'(at_limit),
                (rd ? (m_cnt == MAXC) : (m_cnt == 0)) ? 1 : 0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
